// File: rtl/layer_serializer.sv
// layer_serializer: ping-pong buffer that takes a parallel layer output vector
// (NN words) in one strobe and streams it out one word per accepted cycle.
// Two banks let a new vector land while the previous one is still draining;
// a vector arriving with both banks full is dropped and counted.
//
// state | meaning
// IDLE  | no word presented, o_valid low
// SEND  | o_data holds word o_index of bank rd_ptr, o_valid high
module layer_serializer #(
  parameter int NN        = 10,
  parameter int dataWidth = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_valid,
  input  logic [NN*dataWidth-1:0]               i_data,
  output logic [dataWidth-1:0]                  o_data,
  output logic                                  o_valid,
  input  logic                                  o_ready,
  output logic                                  o_last,
  output logic [((NN > 1) ? $clog2(NN) : 1)-1:0] o_index,
  output logic [CNT_WIDTH-1:0]                  o_drop_cnt,
  output logic                                  o_busy
);

  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                   state_q, state_d;
  logic [NN*dataWidth-1:0]  bank_q [2];
  logic                     wr_ptr_q, rd_ptr_q;
  logic [1:0]               occ_q, occ_d;
  logic                     accept, free_bank, cap, drop;
  logic [dataWidth-1:0]     data_d;
  logic                     valid_d, last_d;
  logic [IW-1:0]            idx_d, idx_inc;

  function automatic logic [dataWidth-1:0] pick(input logic [NN*dataWidth-1:0] vec,
                                                input logic [IW-1:0] k);
    return vec[int'(k)*dataWidth +: dataWidth];
  endfunction

  // A bank is freed when its final word is accepted; that bank may be refilled
  // on the same edge, so a full buffer only drops when nothing is freed.
  assign accept    = o_valid & o_ready;
  assign free_bank = accept & o_last;
  assign cap       = i_valid & ((occ_q != 2'd2) | free_bank);
  assign drop      = i_valid & ~cap;
  assign idx_inc   = o_index + IW'(1);
  assign o_busy    = (occ_q != 2'd0);

  // Occupancy follows captures and frees; both in one cycle leave it unchanged.
  always_comb begin
    occ_d = occ_q;
    case ({cap, free_bank})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Bank storage; contents are only meaningful while counted in occupancy.
  always_ff @(posedge clk) begin
    if (cap && !rst) bank_q[wr_ptr_q] <= i_data;
  end

  // Pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      o_drop_cnt <= '0;
    end else begin
      if (cap)       wr_ptr_q <= ~wr_ptr_q;
      if (free_bank) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
      if (drop && (o_drop_cnt != {CNT_WIDTH{1'b1}}))
        o_drop_cnt <= o_drop_cnt + CNT_WIDTH'(1);
    end
  end

  // Serializer state and registered output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_index <= '0;
    end else begin
      state_q <= state_d;
      o_data  <= data_d;
      o_valid <= valid_d;
      o_last  <= last_d;
      o_index <= idx_d;
    end
  end

  // Next state and next output word; outputs hold unless a word is accepted.
  always_comb begin
    state_d = state_q;
    data_d  = o_data;
    valid_d = o_valid;
    last_d  = o_last;
    idx_d   = o_index;
    case (state_q)
      IDLE: begin
        if (occ_q != 2'd0) begin
          state_d = SEND;
          valid_d = 1'b1;
          idx_d   = '0;
          data_d  = pick(bank_q[rd_ptr_q], '0);
          last_d  = (NN == 1);
        end
      end
      SEND: begin
        if (accept) begin
          if (!o_last) begin
            idx_d  = idx_inc;
            data_d = pick(bank_q[rd_ptr_q], idx_inc);
            last_d = (idx_inc == LAST_IDX);
          end else if (occ_q == 2'd2) begin
            // Other bank already waiting: start it next cycle without a bubble.
            idx_d  = '0;
            data_d = pick(bank_q[~rd_ptr_q], '0);
            last_d = (NN == 1);
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
            idx_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
